// File: rtl/dna_pkg.sv
// Shared DNA digit definitions: 2-bit digit type, symbol codes,
// orientation suffixes and the word_reorient FSM state type.
package dna_pkg;

    typedef logic [1:0] digit_t;

    // Complement is bitwise inversion: SYM1<->SYM2, SYM3<->SYM4.
    localparam digit_t SYM1 = 2'b01;
    localparam digit_t SYM2 = 2'b10;
    localparam digit_t SYM3 = 2'b11;
    localparam digit_t SYM4 = 2'b00;

    // Suffix as {first suffix digit, second suffix digit}.
    localparam logic [3:0] SUFFIX_FWD = {SYM1, SYM4};
    localparam logic [3:0] SUFFIX_REV = {SYM2, SYM3};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECIDE  = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/check_reverse.sv
// Suffix classifier: decides the read orientation of a word from its
// two suffix digits and whether a deletion is suspected in the prefix.
module check_reverse
    import dna_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] suffix,
    output logic         reversed,
    output logic         in_prefix
);

    digit_t hi;
    digit_t lo;

    assign hi = suffix[N-1 -: 2];
    assign lo = suffix[1:0];

    // Priority classification; an intact forward suffix wins, then any
    // forward-looking first digit, then an intact reverse suffix.
    always_comb begin
        reversed  = 1'b1;
        in_prefix = 1'b1;
        if ({hi, lo} == SUFFIX_FWD) begin
            reversed  = 1'b0;
            in_prefix = 1'b0;
        end else if (hi == SYM1 || hi == SYM4) begin
            reversed  = 1'b0;
            in_prefix = 1'b1;
        end else if ({hi, lo} == SUFFIX_REV) begin
            reversed  = 1'b1;
            in_prefix = 1'b0;
        end
    end

endmodule

// File: rtl/word_reorient.sv
// Buffers one serial DNA word, classifies its suffix, then re-emits it in
// forward order or reverse-complemented, tagging the word with its flags.
module word_reorient
    import dna_pkg::*;
#(
    parameter int N = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_digit,
    output logic       out_last,
    output logic       out_reversed,
    output logic       out_in_prefix
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_nxt;
    logic [CW-1:0] rd_idx;
    digit_t        buf_mem [N];
    digit_t        rd_digit;
    logic          rev_d;
    logic          pre_d;

    check_reverse #(.N(4)) u_check_reverse (
        .suffix    ({buf_mem[N-2], buf_mem[N-1]}),
        .reversed  (rev_d),
        .in_prefix (pre_d)
    );

    // Next-state and handshake decode; one index serves both collect and emit.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx == LAST) begin
                        idx_nxt   = '0;
                        state_nxt = DECIDE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DECIDE: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx == LAST) begin
                        idx_nxt   = '0;
                        state_nxt = COLLECT;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
        endcase
    end

    // Control registers; flags are latched once per word in DECIDE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            idx           <= '0;
            out_reversed  <= 1'b0;
            out_in_prefix <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == DECIDE) begin
                out_reversed  <= rev_d;
                out_in_prefix <= pre_d;
            end
        end
    end

    // Digit buffer; contents are meaningless until a full word is collected.
    always_ff @(posedge clk) begin
        if (state == COLLECT && in_valid) begin
            buf_mem[idx] <= in_digit;
        end
    end

    // Reverse emission walks the buffer from the end and complements.
    always_comb begin
        rd_idx    = out_reversed ? (LAST - idx) : idx;
        rd_digit  = buf_mem[rd_idx];
        out_digit = 2'b00;
        out_last  = 1'b0;
        if (state == EMIT) begin
            out_digit = out_reversed ? ~rd_digit : rd_digit;
            out_last  = (idx == LAST);
        end
    end

endmodule

// File: tb/tb_word_reorient.sv
// Bench for word_reorient: directed and randomized words checked against a
// symbol-level reference model of reorientation and suffix classification.
module tb_word_reorient;

    localparam int N = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_digit;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_digit;
    logic       out_last;
    logic       out_reversed;
    logic       out_in_prefix;

    always #5 clk = ~clk;

    word_reorient #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_digit      (in_digit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_digit     (out_digit),
        .out_last      (out_last),
        .out_reversed  (out_reversed),
        .out_in_prefix (out_in_prefix)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] word [N];
    logic [1:0] exp_q [$];
    logic       exp_rev;
    logic       exp_pre;

    logic [1:0] got_q [$];
    logic       got_rev;
    logic       got_pre;
    int         last_cnt;
    int         last_idx;
    int         flag_var;
    int         stall_bad;
    int         inrdy_bad;
    int         decide_cnt;
    bit         cap_timeout;

    // Symbols given as 1..4; symbol 4 is encoded as 00.
    task automatic set_word(input int s0, s1, s2, s3, s4, s5);
        int s [6];
        s = '{s0, s1, s2, s3, s4, s5};
        for (int i = 0; i < N; i++) word[i] = 2'(s[i] % 4);
    endtask

    task automatic rand_word();
        for (int i = 0; i < N; i++) word[i] = 2'($urandom_range(0, 3));
    endtask

    // Reference: classification rules stated on symbols, complement = 3 - code.
    task automatic model();
        logic [1:0] hi;
        logic [1:0] lo;
        hi = word[N-2];
        lo = word[N-1];
        exp_rev = !(hi == 2'd1 || hi == 2'd0);
        exp_pre = !((hi == 2'd1 && lo == 2'd0) || (hi == 2'd2 && lo == 2'd3));
        exp_q.delete();
        for (int k = 0; k < N; k++)
            exp_q.push_back(exp_rev ? 2'd3 - word[N-1-k] : word[k]);
    endtask

    task automatic push_digit(input logic [1:0] d, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_digit = d;
        t = 0;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input int max_gap);
        for (int i = 0; i < N; i++)
            push_digit(word[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    // Records one emitted word; mode 0 ready always, 1 pattern 1,0,0,1, 2 random.
    task automatic capture(input int mode);
        int t;
        int c;
        bit first;
        bit stalled;
        logic [1:0] held_d;
        logic held_l;
        got_q.delete();
        last_cnt = 0; last_idx = -1; flag_var = 0; stall_bad = 0;
        inrdy_bad = 0; decide_cnt = 0; cap_timeout = 0;
        first = 1; stalled = 0; c = 0; t = 0; held_d = 0; held_l = 0;
        while (got_q.size() < N) begin
            if (t >= 1000) begin cap_timeout = 1; break; end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!in_ready && !out_valid) decide_cnt++;
            if (out_valid) begin
                if (in_ready) inrdy_bad++;
                if (first) begin
                    got_rev = out_reversed; got_pre = out_in_prefix; first = 0;
                end else if (out_reversed !== got_rev || out_in_prefix !== got_pre) begin
                    flag_var++;
                end
                if (stalled && (out_digit !== held_d || out_last !== held_l)) stall_bad++;
                if (out_ready) begin
                    got_q.push_back(out_digit);
                    if (out_last) begin last_cnt++; last_idx = got_q.size() - 1; end
                    stalled = 0;
                end else begin
                    stalled = 1; held_d = out_digit; held_l = out_last;
                end
                c++;
            end
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready actual %b required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid actual %b required 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last actual %b required 0", out_last); end
        n_checks++; if (out_digit !== 2'b00) begin n_fail++; $display("FAIL rst_out_digit actual %b required 00", out_digit); end
        n_checks++; if ({out_reversed, out_in_prefix} !== 2'b00) begin n_fail++; $display("FAIL rst_flags actual %b required 00", {out_reversed, out_in_prefix}); end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        set_word(3, 2, 1, 3, 1, 4);
        model();
        send_word(0);
        n_checks++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL fwd_decide_cycle valid,ready actual %b required 00", {out_valid, in_ready}); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_latency out_valid actual %b required 1", out_valid); end
        capture(0);
        n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL fwd_timeout actual %0d digits required %0d", got_q.size(), N); end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL fwd_digit%0d actual %0d required %0d", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if ({got_rev, got_pre} !== 2'b00) begin n_fail++; $display("FAIL fwd_flags actual %b required 00", {got_rev, got_pre}); end
        n_checks++; if (last_cnt != 1 || last_idx != N - 1) begin n_fail++; $display("FAIL fwd_last actual cnt=%0d pos=%0d required cnt=1 pos=%0d", last_cnt, last_idx, N - 1); end
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL fwd_return valid,ready actual %b required 01", {out_valid, in_ready}); end
    endtask

    task automatic test_reverse();
        set_word(1, 2, 4, 1, 2, 3);
        model();
        send_word(0);
        capture(0);
        n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL rev_timeout actual %0d digits required %0d", got_q.size(), N); end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rev_digit%0d actual %0d required %0d", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if ({got_rev, got_pre} !== 2'b10) begin n_fail++; $display("FAIL rev_flags actual %b required 10", {got_rev, got_pre}); end
        n_checks++; if (last_cnt != 1 || last_idx != N - 1 || flag_var != 0) begin n_fail++; $display("FAIL rev_last_flags actual cnt=%0d pos=%0d var=%0d required 1,%0d,0", last_cnt, last_idx, flag_var, N - 1); end
    endtask

    task automatic test_prefix_classes();
        int sfx [4];
        sfx = '{4, 2, 2, 1};
        for (int c = 0; c < 2; c++) begin
            rand_word();
            word[N-2] = 2'(sfx[2*c] % 4);
            word[N-1] = 2'(sfx[2*c+1] % 4);
            model();
            send_word(0);
            capture(0);
            n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL pfx%0d_timeout actual %0d digits required %0d", c, got_q.size(), N); end
            for (int k = 0; k < got_q.size(); k++) begin
                n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL pfx%0d_digit%0d actual %0d required %0d", c, k, got_q[k], exp_q[k]); end
            end
            n_checks++; if ({got_rev, got_pre} !== {exp_rev, exp_pre}) begin n_fail++; $display("FAIL pfx%0d_flags actual %b required %b", c, {got_rev, got_pre}, {exp_rev, exp_pre}); end
        end
    endtask

    task automatic test_backpressure();
        rand_word();
        model();
        send_word(0);
        capture(1);
        n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL bp_timeout actual %0d digits required %0d", got_q.size(), N); end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_digit%0d actual %0d required %0d", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stable actual %0d changes required 0", stall_bad); end
        n_checks++; if (inrdy_bad != 0) begin n_fail++; $display("FAIL bp_in_ready actual %0d high cycles required 0", inrdy_bad); end
        n_checks++; if (flag_var != 0 || {got_rev, got_pre} !== {exp_rev, exp_pre}) begin n_fail++; $display("FAIL bp_flags actual %b var=%0d required %b", {got_rev, got_pre}, flag_var, {exp_rev, exp_pre}); end
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 3; i++) push_digit(2'($urandom_range(0, 3)), 0);
        rst = 1'b1; in_valid = 1'b1; in_digit = 2'd2;
        @(posedge clk); #1;
        n_checks++; if ({in_ready, out_valid, out_last, out_reversed, out_in_prefix, out_digit} !== 7'b1000000) begin n_fail++; $display("FAIL rst_collect actual %b required 1000000", {in_ready, out_valid, out_last, out_reversed, out_in_prefix, out_digit}); end
        rst = 1'b0; in_valid = 1'b0;
        set_word(1, 2, 4, 1, 2, 3);
        send_word(0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({out_valid, out_reversed} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_emit valid,rev actual %b required 11", {out_valid, out_reversed}); end
        rst = 1'b1; in_valid = 1'b1; in_digit = 2'd3;
        @(posedge clk); #1;
        n_checks++; if ({in_ready, out_valid, out_last, out_reversed, out_in_prefix, out_digit} !== 7'b1000000) begin n_fail++; $display("FAIL rst_emit actual %b required 1000000", {in_ready, out_valid, out_last, out_reversed, out_in_prefix, out_digit}); end
        rst = 1'b0; in_valid = 1'b0;
        set_word(3, 2, 1, 3, 1, 4);
        model();
        send_word(0);
        capture(0);
        n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL rst_after_timeout actual %0d digits required %0d", got_q.size(), N); end
        for (int k = 0; k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rst_after_digit%0d actual %0d required %0d", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if ({got_rev, got_pre} !== 2'b00 || last_idx != N - 1) begin n_fail++; $display("FAIL rst_after_flags actual %b last=%0d required 00 last=%0d", {got_rev, got_pre}, last_idx, N - 1); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] w3 [3][N];
        logic [1:0] e3 [3][N];
        logic       r3 [3];
        logic       p3 [3];
        for (int w = 0; w < 3; w++) begin
            rand_word();
            model();
            for (int i = 0; i < N; i++) begin w3[w][i] = word[i]; e3[w][i] = exp_q[i]; end
            r3[w] = exp_rev; p3[w] = exp_pre;
        end
        fork
            begin
                int t;
                in_valid = 1'b1;
                for (int w = 0; w < 3; w++) begin
                    for (int i = 0; i < N; i++) begin
                        in_digit = w3[w][i];
                        t = 0;
                        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                for (int w = 0; w < 3; w++) begin
                    capture(0);
                    n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL b2b%0d_timeout actual %0d digits required %0d", w, got_q.size(), N); end
                    for (int k = 0; k < got_q.size(); k++) begin
                        n_checks++; if (got_q[k] !== e3[w][k]) begin n_fail++; $display("FAIL b2b%0d_digit%0d actual %0d required %0d", w, k, got_q[k], e3[w][k]); end
                    end
                    n_checks++; if ({got_rev, got_pre} !== {r3[w], p3[w]}) begin n_fail++; $display("FAIL b2b%0d_flags actual %b required %b", w, {got_rev, got_pre}, {r3[w], p3[w]}); end
                    n_checks++; if (last_cnt != 1 || last_idx != N - 1) begin n_fail++; $display("FAIL b2b%0d_last actual cnt=%0d pos=%0d required 1,%0d", w, last_cnt, last_idx, N - 1); end
                    n_checks++; if (decide_cnt != 1 || inrdy_bad != 0) begin n_fail++; $display("FAIL b2b%0d_in_ready actual decide=%0d emit_high=%0d required 1,0", w, decide_cnt, inrdy_bad); end
                end
            end
        join
    endtask

    task automatic test_random();
        for (int w = 0; w < 4; w++) begin
            rand_word();
            model();
            send_word(2);
            capture(2);
            n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout actual %0d digits required %0d", w, got_q.size(), N); end
            for (int k = 0; k < got_q.size(); k++) begin
                n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd%0d_digit%0d actual %0d required %0d", w, k, got_q[k], exp_q[k]); end
            end
            n_checks++; if ({got_rev, got_pre} !== {exp_rev, exp_pre} || flag_var != 0 || stall_bad != 0) begin n_fail++; $display("FAIL rnd%0d_flags actual %b var=%0d stall=%0d required %b", w, {got_rev, got_pre}, flag_var, stall_bad, {exp_rev, exp_pre}); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_digit = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_reverse();
        test_prefix_classes();
        test_backpressure();
        test_reset_midword();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
